lcd_pattern_sequencer: RTL and testbench

LCD_PATTERN_SEQUENCER -- requirements
Module: lcd_pattern_sequencer

---
 rtl/lcd_pattern_sequencer.sv | 146 ++++++++++++++
 tb/tb_lcd_pattern_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pattern_sequencer.sv
// LCD test-pattern generator: colour bars, gray ramp, checkerboard and border.
// Patterns advance at frame boundaries, either on request or after a frame count.
module lcd_pattern_sequencer #(
  parameter int unsigned CHECK_SHIFT = 5
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic [10:0] h_disp,
  input  logic [10:0] v_disp,
  input  logic        auto_en,
  input  logic [7:0]  frames_per_pat,
  input  logic        step,
  output logic [15:0] pixel_data,
  output logic [1:0]  pat_idx,
  output logic [7:0]  frame_cnt,
  output logic        frame_start
);

  localparam logic [1:0]  PAT_BAR    = 2'd0;
  localparam logic [1:0]  PAT_RAMP   = 2'd1;
  localparam logic [1:0]  PAT_CHECK  = 2'd2;
  localparam logic [1:0]  PAT_BORDER = 2'd3;

  localparam logic [15:0] COL_WHITE = 16'hFFFF;
  localparam logic [15:0] COL_BLACK = 16'h0000;
  localparam logic [15:0] COL_RED   = 16'hF800;
  localparam logic [15:0] COL_GREEN = 16'h07E0;
  localparam logic [15:0] COL_BLUE  = 16'h001F;

  logic        origin_d_q;
  logic        step_pending_q, step_pending_d;
  logic [1:0]  pat_idx_q, pat_idx_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] pixel_q, pixel_d;

  logic        origin_s;
  logic        boundary_s;
  logic        auto_due_s;
  logic        advance_s;
  logic        in_range_s;
  logic [10:0] bar_w_s;
  logic [10:0] h_last_s;
  logic [10:0] v_last_s;

  assign origin_s   = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
  assign boundary_s = origin_s && !origin_d_q;
  // frames_per_pat is non-zero whenever the subtraction matters, so no underflow
  assign auto_due_s = auto_en && (frames_per_pat != 8'd0) &&
                      (frame_cnt_q >= (frames_per_pat - 8'd1));
  assign advance_s  = boundary_s && (step || step_pending_q || auto_due_s);

  assign in_range_s = (pixel_xpos < h_disp) && (pixel_ypos < v_disp);
  assign bar_w_s    = h_disp / 11'd5;
  assign h_last_s   = h_disp - 11'd1;
  assign v_last_s   = v_disp - 11'd1;

  // State register
  always_ff @(posedge lcd_pclk) begin
    if (!rst_n) begin
      origin_d_q     <= 1'b0;
      step_pending_q <= 1'b0;
      pat_idx_q      <= PAT_BAR;
      frame_cnt_q    <= 8'd0;
      frame_start_q  <= 1'b0;
      pixel_q        <= COL_BLACK;
    end else begin
      origin_d_q     <= origin_s;
      step_pending_q <= step_pending_d;
      pat_idx_q      <= pat_idx_d;
      frame_cnt_q    <= frame_cnt_d;
      frame_start_q  <= frame_start_d;
      pixel_q        <= pixel_d;
    end
  end

  // Pattern / frame-count next state
  always_comb begin
    pat_idx_d      = pat_idx_q;
    frame_cnt_d    = frame_cnt_q;
    step_pending_d = step_pending_q | step;
    frame_start_d  = boundary_s;
    if (advance_s) begin
      pat_idx_d      = pat_idx_q + 2'd1;
      frame_cnt_d    = 8'd0;
      step_pending_d = 1'b0;
    end else if (boundary_s) begin
      frame_cnt_d    = frame_cnt_q + 8'd1;
    end else begin
      frame_cnt_d    = frame_cnt_q;
    end
  end

  // Pixel colour for the current coordinate under the pre-edge pattern
  always_comb begin
    pixel_d = COL_BLACK;
    if (!in_range_s) begin
      pixel_d = COL_BLACK;
    end else begin
      case (pat_idx_q)
        PAT_BAR: begin
          if (pixel_xpos < bar_w_s) begin
            pixel_d = COL_WHITE;
          end else if (pixel_xpos < (bar_w_s << 1)) begin
            pixel_d = COL_BLACK;
          end else if (pixel_xpos < (bar_w_s * 11'd3)) begin
            pixel_d = COL_RED;
          end else if (pixel_xpos < (bar_w_s << 2)) begin
            pixel_d = COL_GREEN;
          end else begin
            pixel_d = COL_BLUE;
          end
        end
        PAT_RAMP: begin
          pixel_d = {pixel_xpos[8:4], pixel_xpos[8:3], pixel_xpos[8:4]};
        end
        PAT_CHECK: begin
          if (pixel_xpos[CHECK_SHIFT] ^ pixel_ypos[CHECK_SHIFT]) begin
            pixel_d = COL_WHITE;
          end else begin
            pixel_d = COL_BLACK;
          end
        end
        PAT_BORDER: begin
          if ((pixel_xpos == 11'd0) || (pixel_xpos == h_last_s) ||
              (pixel_ypos == 11'd0) || (pixel_ypos == v_last_s)) begin
            pixel_d = COL_RED;
          end else begin
            pixel_d = COL_BLUE;
          end
        end
        default: begin
          pixel_d = COL_BLACK;
        end
      endcase
    end
  end

  assign pixel_data  = pixel_q;
  assign pat_idx     = pat_idx_q;
  assign frame_cnt   = frame_cnt_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_lcd_pattern_sequencer.sv
// Randomised bench for lcd_pattern_sequencer with a frame-level reference model.
module tb_lcd_pattern_sequencer;

  localparam int CS = 5;

  logic        lcd_pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] pixel_xpos = 11'd1;
  logic [10:0] pixel_ypos = 11'd1;
  logic [10:0] h_disp = 11'd800;
  logic [10:0] v_disp = 11'd480;
  logic        auto_en = 1'b0;
  logic [7:0]  frames_per_pat = 8'd0;
  logic        step = 1'b0;
  logic [15:0] pixel_data;
  logic [1:0]  pat_idx;
  logic [7:0]  frame_cnt;
  logic        frame_start;

  int chk_cnt = 0;
  int pass_cnt = 0;

  // reference model state
  int m_pat = 0, m_cnt = 0, m_pend = 0, m_prev_org = 0, m_fs = 0, m_pix = 0;

  lcd_pattern_sequencer #(.CHECK_SHIFT(CS)) dut (
    .lcd_pclk(lcd_pclk), .rst_n(rst_n),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .h_disp(h_disp), .v_disp(v_disp),
    .auto_en(auto_en), .frames_per_pat(frames_per_pat), .step(step),
    .pixel_data(pixel_data), .pat_idx(pat_idx),
    .frame_cnt(frame_cnt), .frame_start(frame_start)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  function automatic int ref_pix(int x, int y, int pat);
    int h, v, w, band, g;
    h = int'(h_disp);
    v = int'(v_disp);
    if (x >= h || y >= v) return 0;
    case (pat)
      0: begin
        w = h / 5;
        band = (w == 0) ? 4 : x / w;
        if (band > 4) band = 4;
        case (band)
          0: return 'hFFFF;
          1: return 'h0000;
          2: return 'hF800;
          3: return 'h07E0;
          default: return 'h001F;
        endcase
      end
      1: begin
        g = x % 512;
        return (g / 16) * 2048 + (g / 8) * 32 + (g / 16);
      end
      2: return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 'hFFFF : 'h0000;
      default: return (x == 0 || x == h - 1 || y == 0 || y == v - 1) ? 'hF800 : 'h001F;
    endcase
  endfunction

  task automatic model_edge(input int x, input int y, input int st);
    int org, bnd, due, pix;
    pix = ref_pix(x, y, m_pat);
    if (!rst_n) begin
      m_pat = 0; m_cnt = 0; m_pend = 0; m_prev_org = 0; m_fs = 0; m_pix = 0;
    end else begin
      org = (x == 0 && y == 0) ? 1 : 0;
      bnd = (org == 1 && m_prev_org == 0) ? 1 : 0;
      due = (st != 0 || m_pend != 0 ||
             (auto_en && frames_per_pat != 0 && m_cnt + 1 >= int'(frames_per_pat))) ? 1 : 0;
      if (bnd == 1 && due == 1) begin
        m_pat = (m_pat + 1) % 4; m_cnt = 0; m_pend = 0;
      end else begin
        if (bnd == 1) m_cnt = (m_cnt + 1) % 256;
        if (st != 0) m_pend = 1;
      end
      m_fs = bnd; m_prev_org = org; m_pix = pix;
    end
  endtask

  task automatic drive(input int x, input int y, input int st);
    pixel_xpos = x[10:0];
    pixel_ypos = y[10:0];
    step = (st != 0);
    model_edge(x, y, st);
    @(posedge lcd_pclk);
    #1;
    step = 1'b0;
  endtask

  // n cycles of active video that never touch the origin
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) drive($urandom_range(1, 40), $urandom_range(0, 40), 0);
  endtask

  task automatic advance_once();
    gap(2);
    drive(3, 3, 1);
    gap(2);
    drive(0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) drive($urandom_range(0, 700), $urandom_range(0, 400), 1);
    chk_cnt++; if (pixel_data !== 16'h0000) $display("FAIL reset_pix: got %h want 0000", pixel_data); else pass_cnt++;
    chk_cnt++; if (pat_idx !== 2'd0) $display("FAIL reset_pat: got %0d want 0", pat_idx); else pass_cnt++;
    chk_cnt++; if (frame_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", frame_cnt); else pass_cnt++;
    chk_cnt++; if (frame_start !== 1'b0) $display("FAIL reset_fs: got %0d want 0", frame_start); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_bar();
    h_disp = 11'd800; v_disp = 11'd480;
    drive(159, 7, 0);
    chk_cnt++; if (pixel_data !== 16'hFFFF) $display("FAIL bar_159: got %h want FFFF", pixel_data); else pass_cnt++;
    drive(160, 7, 0);
    chk_cnt++; if (pixel_data !== 16'h0000) $display("FAIL bar_160: got %h want 0000", pixel_data); else pass_cnt++;
    drive(799, 7, 0);
    chk_cnt++; if (pixel_data !== 16'h001F) $display("FAIL bar_799: got %h want 001F", pixel_data); else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(1, 830), $urandom_range(0, 500), 0);
      chk_cnt++; if (pixel_data !== m_pix[15:0]) $display("FAIL bar_rand: x=%0d got %h want %h", pixel_xpos, pixel_data, m_pix[15:0]); else pass_cnt++;
    end
  endtask

  task automatic test_ramp();
    h_disp = 11'd1500; v_disp = 11'd600;
    advance_once();
    chk_cnt++; if (pat_idx !== 2'd1) $display("FAIL ramp_pat: got %0d want 1", pat_idx); else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(1, 1520), $urandom_range(0, 620), 0);
      chk_cnt++; if (pixel_data !== m_pix[15:0]) $display("FAIL ramp_rand: x=%0d got %h want %h", pixel_xpos, pixel_data, m_pix[15:0]); else pass_cnt++;
    end
  endtask

  task automatic test_check();
    h_disp = 11'd640; v_disp = 11'd480;
    advance_once();
    chk_cnt++; if (pat_idx !== 2'd2) $display("FAIL check_pat: got %0d want 2", pat_idx); else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(1, 660), $urandom_range(0, 500), 0);
      chk_cnt++; if (pixel_data !== m_pix[15:0]) $display("FAIL check_rand: x=%0d y=%0d got %h want %h", pixel_xpos, pixel_ypos, pixel_data, m_pix[15:0]); else pass_cnt++;
    end
  endtask

  task automatic test_border();
    int xs[5] = '{0, 479, 10, 10, 480};
    int ys[5] = '{5, 100, 271, 10, 10};
    logic [15:0] exp_pix[5] = '{16'hF800, 16'hF800, 16'hF800, 16'h001F, 16'h0000};
    h_disp = 11'd480; v_disp = 11'd272;
    advance_once();
    chk_cnt++; if (pat_idx !== 2'd3) $display("FAIL border_pat: got %0d want 3", pat_idx); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      drive(xs[i], ys[i], 0);
      chk_cnt++; if (pixel_data !== exp_pix[i]) $display("FAIL border_dir: (%0d,%0d) got %h want %h", xs[i], ys[i], pixel_data, exp_pix[i]); else pass_cnt++;
    end
    for (int i = 0; i < 30; i++) begin
      drive($urandom_range(0, 1) ? 479 : $urandom_range(1, 490), $urandom_range(0, 1) ? 271 : $urandom_range(1, 280), 0);
      chk_cnt++; if (pixel_data !== m_pix[15:0]) $display("FAIL border_rand: got %h want %h", pixel_data, m_pix[15:0]); else pass_cnt++;
    end
  endtask

  task automatic test_auto();
    int exp_pat[7] = '{0, 0, 1, 1, 1, 2, 2};
    int exp_cnt[7] = '{1, 2, 0, 1, 2, 0, 1};
    advance_once();
    chk_cnt++; if (pat_idx !== 2'd0 || frame_cnt !== 8'd0) $display("FAIL auto_start: pat %0d cnt %0d want 0 0", pat_idx, frame_cnt); else pass_cnt++;
    auto_en = 1'b1; frames_per_pat = 8'd3;
    for (int b = 0; b < 7; b++) begin
      gap($urandom_range(3, 10));
      drive(0, 0, 0);
      chk_cnt++; if (frame_start !== 1'b1) $display("FAIL auto_fs: boundary %0d got %0d want 1", b + 1, frame_start); else pass_cnt++;
      chk_cnt++; if (pat_idx !== exp_pat[b][1:0] || frame_cnt !== exp_cnt[b][7:0])
        $display("FAIL auto_seq: boundary %0d got pat %0d cnt %0d want %0d %0d", b + 1, pat_idx, frame_cnt, exp_pat[b], exp_cnt[b]);
      else pass_cnt++;
    end
    // raise the threshold, count a few frames, toggle auto_en, then lower it
    frames_per_pat = 8'd10;
    for (int b = 0; b < 3; b++) begin gap(3); drive(0, 0, 0); end
    auto_en = 1'b0; gap(2); auto_en = 1'b1;
    chk_cnt++; if (frame_cnt !== 8'd4) $display("FAIL auto_toggle: got cnt %0d want 4", frame_cnt); else pass_cnt++;
    frames_per_pat = 8'd2;
    gap(3); drive(0, 0, 0);
    chk_cnt++; if (pat_idx !== 2'd3 || frame_cnt !== 8'd0) $display("FAIL auto_lower: got pat %0d cnt %0d want 3 0", pat_idx, frame_cnt); else pass_cnt++;
    auto_en = 1'b0; frames_per_pat = 8'd0;
  endtask

  task automatic test_step();
    int p0;
    p0 = m_pat;
    gap(3);
    drive(5, 5, 1);
    for (int i = 0; i < 5; i++) begin
      drive($urandom_range(1, 40), $urandom_range(1, 40), 0);
      chk_cnt++; if (pat_idx !== p0[1:0]) $display("FAIL step_hold: got %0d want %0d", pat_idx, p0); else pass_cnt++;
    end
    drive(0, 0, 0);
    chk_cnt++; if (pat_idx !== 2'((p0 + 1) % 4) || frame_cnt !== 8'd0) $display("FAIL step_adv: got pat %0d cnt %0d want %0d 0", pat_idx, frame_cnt, (p0 + 1) % 4); else pass_cnt++;
    gap(4); drive(0, 0, 0);
    chk_cnt++; if (pat_idx !== 2'((p0 + 1) % 4) || frame_cnt !== 8'd1) $display("FAIL step_consumed: got pat %0d cnt %0d want %0d 1", pat_idx, frame_cnt, (p0 + 1) % 4); else pass_cnt++;
    gap(4); drive(0, 0, 1);
    chk_cnt++; if (pat_idx !== 2'((p0 + 2) % 4) || frame_cnt !== 8'd0) $display("FAIL step_same: got pat %0d cnt %0d want %0d 0", pat_idx, frame_cnt, (p0 + 2) % 4); else pass_cnt++;
  endtask

  task automatic test_blanking();
    int pulses, exp_cnt;
    gap(5);
    exp_cnt = (m_cnt + 1) % 256;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      drive(0, 0, 0);
      if (frame_start === 1'b1) pulses++;
    end
    chk_cnt++; if (pulses != 1) $display("FAIL blank_pulses: got %0d want 1", pulses); else pass_cnt++;
    chk_cnt++; if (frame_cnt !== exp_cnt[7:0]) $display("FAIL blank_cnt: got %0d want %0d", frame_cnt, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    gap(3);
    drive(7, 3, 1);
    gap(2);
    rst_n = 1'b0; drive(9, 9, 0); rst_n = 1'b1;
    chk_cnt++; if (pat_idx !== 2'd0 || frame_cnt !== 8'd0 || pixel_data !== 16'h0000) $display("FAIL rstmid_state: got pat %0d cnt %0d pix %h want 0 0 0000", pat_idx, frame_cnt, pixel_data); else pass_cnt++;
    drive(0, 0, 0);
    chk_cnt++; if (frame_start !== 1'b1 || pat_idx !== 2'd0 || frame_cnt !== 8'd1) $display("FAIL rstmid_next: got fs %0d pat %0d cnt %0d want 1 0 1", frame_start, pat_idx, frame_cnt); else pass_cnt++;
    // reset beats a simultaneous boundary and step; origin held across release
    gap(3);
    rst_n = 1'b0; drive(0, 0, 1); rst_n = 1'b1;
    chk_cnt++; if (frame_start !== 1'b0 || pat_idx !== 2'd0 || frame_cnt !== 8'd0) $display("FAIL rst_prio: got fs %0d pat %0d cnt %0d want 0 0 0", frame_start, pat_idx, frame_cnt); else pass_cnt++;
    drive(0, 0, 0);
    chk_cnt++; if (frame_start !== 1'b1 || pat_idx !== 2'd0 || frame_cnt !== 8'd1) $display("FAIL rst_release: got fs %0d pat %0d cnt %0d want 1 0 1", frame_start, pat_idx, frame_cnt); else pass_cnt++;
  endtask

  task automatic test_random();
    h_disp = 11'd5; v_disp = 11'd4;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        auto_en = 1'($urandom_range(0, 1));
        frames_per_pat = 8'($urandom_range(0, 4));
      end
      rst_n = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 4) == 0) drive(0, 0, ($urandom_range(0, 7) == 0) ? 1 : 0);
      else drive($urandom_range(0, 6), $urandom_range(0, 5), ($urandom_range(0, 7) == 0) ? 1 : 0);
      chk_cnt++;
      if (pixel_data !== m_pix[15:0] || pat_idx !== m_pat[1:0] || frame_cnt !== m_cnt[7:0] || frame_start !== m_fs[0])
        $display("FAIL rand_cycle %0d: got pix %h pat %0d cnt %0d fs %0d want %h %0d %0d %0d",
                 i, pixel_data, pat_idx, frame_cnt, frame_start, m_pix[15:0], m_pat, m_cnt, m_fs);
      else pass_cnt++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_bar();
    test_ramp();
    test_check();
    test_border();
    test_auto();
    test_step();
    test_blanking();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
